// File: rtl/jk_bank_writer.sv
// -----------------------------------------------------------------------------
// jk_bank_writer
//
// Write-side driver for a bank of WIDTH JK flip-flops. A requested word is
// accepted on a valid/ready handshake and turned into per-bit J/K excitation
// from the bank's current Q. The bank is pulsed for one clock. After SETTLE
// quiet cycles Q is read back and compared with the request. On a mismatch the
// bank is re-driven, up to MAX_RETRY extra times. Completion and final error
// are reported per request.
//
// Ports
//   iClk       clock, rising edge
//   iRst_n     asynchronous active-low reset
//   iTarget    requested bank value, sampled on accept only
//   iValid     request valid
//   oReady     high in IDLE; accept = iValid && oReady at a rising edge
//   iQ         readback of the bank's Q outputs
//   oJ, oK     registered J/K inputs to the bank, nonzero only while driving
//   oBusy      high in any state other than IDLE
//   oDone      one-cycle pulse when a request finishes (pass or fail)
//   oError     one-cycle pulse with oDone when the final check failed
//   oMismatch  registered target ^ iQ from the most recent check
// -----------------------------------------------------------------------------
module jk_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2,
    parameter int SETTLE    = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iTarget,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iQ,
    output logic [WIDTH-1:0] oJ,
    output logic [WIDTH-1:0] oK,
    output logic             oBusy,
    output logic             oDone,
    output logic             oError,
    output logic [WIDTH-1:0] oMismatch
);

    localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // The settle counter counts down from SETTLE-1 to 0.
    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [RETRY_W-1:0]  RETRY_LAST  = RETRY_W'(MAX_RETRY);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE
    } state_t;

    state_t               state, stateNext;
    logic [WIDTH-1:0]     target, targetNext;
    logic [RETRY_W-1:0]   retryCnt, retryNext;
    logic [SETTLE_W-1:0]  settleCnt, settleNext;
    logic [WIDTH-1:0]     jNext, kNext, mismatchNext;
    logic                 doneNext, errorNext;

    // Only bits that must change are excited, and never both J and K, so a
    // repeated drive of the same target cannot toggle a bit past its goal.
    function automatic logic [WIDTH-1:0] setBits(input logic [WIDTH-1:0] t,
                                                 input logic [WIDTH-1:0] q);
        return t & ~q;
    endfunction

    function automatic logic [WIDTH-1:0] clrBits(input logic [WIDTH-1:0] t,
                                                 input logic [WIDTH-1:0] q);
        return ~t & q;
    endfunction

    assign oReady = (state == S_IDLE);
    assign oBusy  = (state != S_IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        stateNext    = state;
        targetNext   = target;
        retryNext    = retryCnt;
        settleNext   = settleCnt;
        jNext        = '0;
        kNext        = '0;
        doneNext     = 1'b0;
        errorNext    = 1'b0;
        mismatchNext = oMismatch;

        unique case (state)
            S_IDLE: begin
                if (iValid) begin
                    targetNext = iTarget;
                    retryNext  = '0;
                    jNext      = setBits(iTarget, iQ);
                    kNext      = clrBits(iTarget, iQ);
                    stateNext  = S_DRIVE;
                end
            end

            S_DRIVE: begin
                // J/K fall back to zero here through the defaults above.
                settleNext = SETTLE_LOAD;
                stateNext  = S_SETTLE;
            end

            S_SETTLE: begin
                if (settleCnt != '0) begin
                    settleNext = settleCnt - SETTLE_W'(1);
                end else begin
                    mismatchNext = target ^ iQ;
                    if (target == iQ) begin
                        doneNext  = 1'b1;
                        stateNext = S_IDLE;
                    end else if (retryCnt != RETRY_LAST) begin
                        retryNext = retryCnt + RETRY_W'(1);
                        jNext     = setBits(target, iQ);
                        kNext     = clrBits(target, iQ);
                        stateNext = S_DRIVE;
                    end else begin
                        doneNext  = 1'b1;
                        errorNext = 1'b1;
                        stateNext = S_IDLE;
                    end
                end
            end

            default: stateNext = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments only in this clocked process, so every
    // flop samples the pre-edge values computed by the combinational block.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            // NOTE: this block holds only control and data flops (no memory
            // arrays), so all of them reset; an in-flight request is dropped.
            state     <= S_IDLE;
            target    <= '0;
            retryCnt  <= '0;
            settleCnt <= '0;
            oJ        <= '0;
            oK        <= '0;
            oDone     <= 1'b0;
            oError    <= 1'b0;
            oMismatch <= '0;
        end else begin
            state     <= stateNext;
            target    <= targetNext;
            retryCnt  <= retryNext;
            settleCnt <= settleNext;
            oJ        <= jNext;
            oK        <= kNext;
            oDone     <= doneNext;
            oError    <= errorNext;
            oMismatch <= mismatchNext;
        end
    end

endmodule

// File: tb/tb_jk_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_writer
//
// Bench for jk_bank_writer with default parameters. A behavioural JK bank
// (with an optional stuck-at-0 mask) closes the loop on iQ. Every accepted
// request pushes its expected outcome onto a scoreboard queue; the entry is
// popped and compared when oDone is seen.
// -----------------------------------------------------------------------------
module tb_jk_bank_writer;

    localparam int WIDTH     = 8;
    localparam int MAX_RETRY = 2;
    localparam int SETTLE    = 1;

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic [WIDTH-1:0] iTarget;
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iQ;
    logic [WIDTH-1:0] oJ;
    logic [WIDTH-1:0] oK;
    logic             oBusy;
    logic             oDone;
    logic             oError;
    logic [WIDTH-1:0] oMismatch;

    always #5 iClk = ~iClk;

    jk_bank_writer #(
        .WIDTH    (WIDTH),
        .MAX_RETRY(MAX_RETRY),
        .SETTLE   (SETTLE)
    ) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iTarget  (iTarget),
        .iValid   (iValid),
        .oReady   (oReady),
        .iQ       (iQ),
        .oJ       (oJ),
        .oK       (oK),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oError   (oError),
        .oMismatch(oMismatch)
    );

    // ---------------- check bookkeeping ----------------
    int passCount  = 0;
    int checkCount = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
        else
            passCount++;
    endtask

    // ---------------- behavioural JK bank ----------------
    logic [WIDTH-1:0] bankQ  = '0;
    logic [WIDTH-1:0] stuck0 = '0;
    logic [WIDTH-1:0] setVal = '0;
    logic             setReq = 1'b0;

    assign iQ = bankQ;

    always @(posedge iClk) begin
        if (setReq) bankQ <= setVal;
        else        bankQ <= ((oJ & ~bankQ) | (~oK & bankQ)) & ~stuck0;
    end

    task automatic setBank(input logic [WIDTH-1:0] v);
        @(negedge iClk);
        setVal = v;
        setReq = 1'b1;
        @(negedge iClk);
        setReq = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] firstJ;
        logic [WIDTH-1:0] firstK;
        logic [WIDTH-1:0] expMis;
        logic [WIDTH-1:0] expFinal;
        logic             expErr;
        int               expLat;
        int               expDrives;
        int               acceptCyc;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    int cyc            = 0;
    int acceptCount    = 0;
    int lastAcceptCyc  = 0;
    int driveCnt       = 0;
    int doneCount      = 0;
    int toggleViol     = 0;
    int consecViol     = 0;
    int unexpectedDone = 0;
    int strayError     = 0;
    bit prevNz         = 1'b0;

    // Accept monitor: values read here are the pre-edge ones.
    always @(posedge iClk) begin : acceptMon
        sbEntry_t e;
        cyc++;
        if (iRst_n && iValid && oReady) begin
            e.target    = iTarget;
            e.firstJ    = iTarget & ~bankQ;
            e.firstK    = ~iTarget & bankQ;
            e.expFinal  = iTarget & ~stuck0;
            e.expMis    = iTarget ^ e.expFinal;
            e.expErr    = (e.expMis != '0);
            e.expLat    = e.expErr ? (1 + MAX_RETRY) * (1 + SETTLE) + 1 : 2 + SETTLE;
            e.expDrives = e.expErr ? 1 + MAX_RETRY : ((iTarget != bankQ) ? 1 : 0);
            e.acceptCyc = cyc;
            sbQ.push_back(e);
            driveCnt      = 0;
            lastAcceptCyc = cyc;
            acceptCount++;
        end
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge iClk) begin : outMon
        sbEntry_t e;
        bit nz;
        if (iRst_n) begin
            nz = ((oJ | oK) != '0);
            if ((oJ & oK) != '0) toggleViol++;
            if (nz && prevNz)    consecViol++;
            prevNz = nz;
            if (oError && !oDone) strayError++;

            if (sbQ.size() > 0) begin
                if (cyc == sbQ[0].acceptCyc) begin
                    check("firstJ", oJ, sbQ[0].firstJ);
                    check("firstK", oK, sbQ[0].firstK);
                end
                if (nz) begin
                    driveCnt++;
                    check("driveJ", oJ, sbQ[0].target & ~bankQ);
                    check("driveK", oK, ~sbQ[0].target & bankQ);
                end
                if (oDone) begin
                    e = sbQ.pop_front();
                    doneCount++;
                    check("latency",  cyc - e.acceptCyc + 1, e.expLat);
                    check("error",    oError,    e.expErr);
                    check("mismatch", oMismatch, e.expMis);
                    check("bankQ",    bankQ,     e.expFinal);
                    check("drives",   driveCnt,  e.expDrives);
                end
            end else if (oDone) begin
                unexpectedDone++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic waitAccept(input int prev);
        int n = 0;
        while (acceptCount == prev && n < 100) begin
            @(posedge iClk);
            #1;
            n++;
        end
        if (acceptCount == prev) check("acceptTimeout", acceptCount, prev + 1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (sbQ.size() != 0) check("drainTimeout", sbQ.size(), 0);
    endtask

    // Returns at the negedge of the DRIVE cycle.
    task automatic sendReq(input logic [WIDTH-1:0] v);
        int prev;
        @(negedge iClk);
        iValid  = 1'b1;
        iTarget = v;
        prev    = acceptCount;
        waitAccept(prev);
        @(negedge iClk);
        iValid  = 1'b0;
        iTarget = WIDTH'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin : mainSeq
        int a1;
        int a2;
        int prev;

        iRst_n  = 1'b0;
        iValid  = 1'b0;
        iTarget = '0;
        setVal  = '0;
        setReq  = 1'b1;
        repeat (3) @(negedge iClk);
        check("rstReady",    oReady,    1);
        check("rstBusy",     oBusy,     0);
        check("rstJ",        oJ,        0);
        check("rstK",        oK,        0);
        check("rstDone",     oDone,     0);
        check("rstError",    oError,    0);
        check("rstMismatch", oMismatch, 0);
        setReq = 1'b0;
        iRst_n = 1'b1;
        @(negedge iClk);

        // 0x00 -> 0xA5: pure set.
        sendReq(8'hA5);
        waitDrain();

        // 0xFF -> 0x0F: pure clear.
        setBank(8'hFF);
        sendReq(8'h0F);
        waitDrain();

        // Back-to-back: 0x99 held valid while busy, taken in the oDone cycle.
        @(negedge iClk);
        iValid  = 1'b1;
        iTarget = 8'h3C;
        prev    = acceptCount;
        waitAccept(prev);
        a1 = lastAcceptCyc;
        @(negedge iClk);
        iTarget = 8'h99;
        waitAccept(prev + 1);
        a2 = lastAcceptCyc;
        check("acceptGap", a2 - a1, 2 + SETTLE);
        @(negedge iClk);
        iValid = 1'b0;
        waitDrain();

        // Bit 0 stuck at 0: every retry fails, error after all attempts.
        setBank(8'h00);
        stuck0 = 8'h01;
        sendReq(8'h01);
        waitDrain();

        // Asynchronous reset in the middle of SETTLE.
        stuck0 = 8'h00;
        sendReq(8'hFF);
        @(negedge iClk);
        check("preRstBusy", oBusy, 1);
        #2;
        iRst_n = 1'b0;
        #1;
        check("abortJ",        oJ,        0);
        check("abortK",        oK,        0);
        check("abortDone",     oDone,     0);
        check("abortError",    oError,    0);
        check("abortMismatch", oMismatch, 0);
        check("abortBusy",     oBusy,     0);
        check("abortReady",    oReady,    1);
        sbQ.delete();
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        repeat (8) @(negedge iClk);

        // Target already equal to Q: full cycle with zero excitation.
        setBank(8'h5A);
        sendReq(8'h5A);
        waitDrain();

        repeat (3) @(negedge iClk);
        check("doneCount",      doneCount,      6);
        check("noToggle",       toggleViol,     0);
        check("noConsecDrive",  consecViol,     0);
        check("noAbortedDone",  unexpectedDone, 0);
        check("noStrayError",   strayError,     0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/jk_bank_writer.md
# jk_bank_writer

Write-side driver for a bank of WIDTH JK flip-flops. It accepts a target word on a valid/ready handshake and converts it to per-bit J/K excitation from the bank's current Q. It pulses the bank for one clock, reads Q back, and retries on mismatch up to MAX_RETRY times. It sits between control logic that wants a register value loaded and a JK flip-flop bank, and reports completion and error per request.

## Interface
- WIDTH, 8, number of JK flip-flops in the driven bank (≥1)
- MAX_RETRY, 2, extra drive attempts after a failed first check (≥0)
- SETTLE, 1, cycles J/K are held at 0 after a drive before Q is compared (≥1)

- iClk  in  1  clock; all state changes on the rising edge
- iRst_n  in  1  asynchronous, active-low reset
- iTarget  in  WIDTH  requested bank value; sampled only on accept
- iValid  in  1  request valid
- oReady  out  1  high only in IDLE; accept = iValid && oReady at a rising edge
- iQ  in  WIDTH  readback of the bank's Q outputs
- oJ  out  WIDTH  J inputs to the bank, registered
- oK  out  WIDTH  K inputs to the bank, registered
- oBusy  out  1  high in any state other than IDLE
- oDone  out  1  one-cycle pulse when a request finishes, pass or fail
- oError  out  1  one-cycle pulse coincident with oDone when the final check failed
- oMismatch  out  WIDTH  registered target XOR iQ from the last check; held until the next check

## Operation
- States: IDLE, DRIVE, SETTLE.
- Excitation is computed per bit from the latched target T and the current iQ:
  - 0→1: J=1, K=0
  - 1→0: J=0, K=1
  - hold (either value): J=0, K=0
  - J=K=1 (toggle) is never driven, so every drive is idempotent.
- IDLE: oJ=oK=0.
  - On accept: latch iTarget into T, clear the retry count, register the excitation into oJ/oK, and go to DRIVE.
- DRIVE: lasts exactly one cycle with oJ/oK applied.
  - At the next edge: oJ=oK=0, load the settle counter, and go to SETTLE.
- SETTLE: lasts SETTLE cycles with oJ=oK=0. At the edge that ends the last cycle, compare iQ with T and register oMismatch:
  - Equal: oDone=1, and go to IDLE.
  - Unequal and retries < MAX_RETRY: increment retries, register a new excitation from the current iQ, and go to DRIVE.
  - Unequal and retries == MAX_RETRY: oDone=1, oError=1, and go to IDLE.
- A target equal to iQ at accept still runs a full DRIVE (all-zero J/K) and a full SETTLE.
- iTarget changes after accept are ignored. iValid while oReady=0 is ignored and not queued.
- The retry counter is $clog2(MAX_RETRY+1) bits wide (minimum 1). MAX_RETRY=0 means the first mismatch is final.

## Timing
- Reset (async assert, any state): state=IDLE, oJ=0, oK=0, oDone=0, oError=0, oMismatch=0, oBusy=0, oReady=1.
  - An in-flight request is abandoned with no oDone.
  - Release is synchronous to iClk.
- Accept at edge E0 gives:
  - DRIVE during cycle E0..E1.
  - SETTLE during E1..E(1+SETTLE).
  - Check at edge E(1+SETTLE).
- Passing first attempt: oDone high during E(1+SETTLE)..E(2+SETTLE), i.e. 2+SETTLE cycles after accept. Default parameters give 3.
- Each retry adds 1+SETTLE cycles. Worst case: oDone at (1+MAX_RETRY)·(1+SETTLE)+1 cycles after accept.
- oReady is high in the oDone cycle, so a new request may be accepted in that cycle. Back-to-back throughput is one request per 2+SETTLE cycles.
- oJ/oK are nonzero only in DRIVE cycles. They are never nonzero for two consecutive cycles.

## Test plan
- Bench model bank starts at Q=0x00; request 0xA5 (default parameters).
  - Required: oJ=0xA5, oK=0x00 for one cycle.
  - oDone=1, oError=0, oMismatch=0x00 exactly 3 cycles after accept; bank reads 0xA5.
- Q=0xFF; request 0x0F.
  - Required: oJ=0x00, oK=0xF0.
  - No bit ever has J=K=1; done after 3 cycles.
- Bank bit 0 stuck at 0; request 0x01; MAX_RETRY=2.
  - Required: three DRIVE cycles, each with oJ=0x01.
  - oDone and oError together 7 cycles after accept; oMismatch=0x01.
- Request 0x3C; hold iValid high with 0x99 during the busy period, then keep iValid high.
  - Required: 0x99 is accepted only in the oDone cycle.
  - Second oDone 3 cycles later; bank reads 0x99.
- Assert iRst_n=0 during SETTLE.
  - Required: oJ/oK/oDone/oError/oMismatch/oBusy go to 0 and oReady to 1 immediately, without waiting for a clock edge.
  - No oDone is ever issued for the aborted request.
- Request equal to the current Q (0x5A).
  - Required: DRIVE cycle with oJ=oK=0x00; oDone after 3 cycles, no error.
